iq_ddc_demod: RTL and testbench

Receive-side counterpart of the AWG IQ upconverter. It takes offset-binary ADC samples and mixes them with the cos/sin LO pair from the existing ROM NCO. The I and Q products go through an integrate-and-dump decimator with a selectable power-of-two ratio. Output is signed baseband I/Q with a single-cycle valid strobe, feeding capture/PMOD debug logic.

---
 rtl/ddc_pkg.sv | 40 ++++
 rtl/iq_mix_lane.sv | 56 +++++
 rtl/iq_ddc_demod.sv | 105 ++++++++++
 tb/tb_iq_ddc_demod.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddc_pkg.sv
// Shared types and helpers for the IQ downconverter: sample width, decimation
// limits, product saturation and decimation-ratio clamping.
package ddc_pkg;

    localparam int DATA_W       = 16;
    localparam int MAX_DEC_LOG2 = 8;
    localparam int ACC_W        = DATA_W + MAX_DEC_LOG2;

    typedef logic signed [DATA_W-1:0]   sample_t;
    typedef logic signed [2*DATA_W-1:0] prod_t;

    typedef struct packed {
        logic    ovf;
        sample_t val;
    } sat_t;

    // Clip a scaled product into sample range, flagging when clipping happened.
    function automatic sat_t sat16(input prod_t p);
        sat_t    r;
        sample_t max_v;
        sample_t min_v;
        max_v = {1'b0, {(DATA_W-1){1'b1}}};
        min_v = {1'b1, {(DATA_W-1){1'b0}}};
        r.ovf = 1'b0;
        r.val = p[DATA_W-1:0];
        if (p > prod_t'(max_v)) begin
            r.ovf = 1'b1;
            r.val = max_v;
        end else if (p < prod_t'(min_v)) begin
            r.ovf = 1'b1;
            r.val = min_v;
        end
        return r;
    endfunction

    function automatic logic [3:0] clamp_dec(input logic [3:0] d);
        return (d > 4'(MAX_DEC_LOG2)) ? 4'(MAX_DEC_LOG2) : d;
    endfunction

endpackage

// File: rtl/iq_mix_lane.sv
// One mixer lane: multiply sample by LO, saturate, then integrate-and-dump
// with a power-of-two shift on the last sample of each block.
module iq_mix_lane
    import ddc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  sample_t    x,
    input  sample_t    lo,
    input  logic       mul_vld,
    input  logic       acc_vld,
    input  logic       acc_clr,
    input  logic       acc_last,
    input  logic [3:0] d,
    output sample_t    out,
    output logic       ovf
);

    prod_t                   prod_sh;
    sat_t                    s;
    sample_t                 p;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] dump;

    always_comb begin
        prod_sh = (prod_t'(x) * prod_t'(lo)) >>> (DATA_W-1);
        s       = sat16(prod_sh);
        ovf     = s.ovf;
        // A clr tag riding with a sample makes that sample the first of a fresh block.
        acc_sum = (acc_clr ? '0 : acc) + ACC_W'(p);
        dump    = acc_sum >>> d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p   <= '0;
            acc <= '0;
            out <= '0;
        end else begin
            if (mul_vld)
                p <= s.val;
            if (acc_vld) begin
                if (acc_last) begin
                    acc <= '0;
                    out <= dump[DATA_W-1:0];
                end else begin
                    acc <= acc_sum;
                end
            end else if (acc_clr) begin
                acc <= '0;
            end
        end
    end

endmodule

// File: rtl/iq_ddc_demod.sv
// IQ digital downconverter: offset-binary ADC x NCO cos/sin, followed by a
// selectable power-of-two integrate-and-dump decimator per lane.
module iq_ddc_demod #(
    parameter int DATA_W       = 16,
    parameter int MAX_DEC_LOG2 = 8,
    parameter int ACC_W        = DATA_W + MAX_DEC_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] adc_in,
    input  logic [DATA_W-1:0] lo_i,
    input  logic [DATA_W-1:0] lo_q,
    input  logic [3:0]        dec_log2,
    input  logic              blk_clr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_i,
    output logic [DATA_W-1:0] out_q,
    output logic              sat_flag
);

    import ddc_pkg::sample_t;
    import ddc_pkg::clamp_dec;

    // Lane arithmetic is sized from the package, so the parameters must agree with it.
    if (DATA_W != ddc_pkg::DATA_W || MAX_DEC_LOG2 != ddc_pkg::MAX_DEC_LOG2 ||
        ACC_W != ddc_pkg::ACC_W) begin : g_param_chk
        $error("iq_ddc_demod parameters must match ddc_pkg");
    end

    logic [1:0]              vld_pipe;  // [0] capture stage, [1] multiply stage
    logic [1:0]              clr_pipe;
    sample_t                 x1, lo_i1, lo_q1;
    logic [MAX_DEC_LOG2-1:0] cnt, cnt_eff, n_m1;
    logic [3:0]              d_q, d_eff;
    logic                    last, ovf_i, ovf_q;

    always_comb begin
        cnt_eff = clr_pipe[1] ? '0 : cnt;
        // The ratio is sampled live at the start of each block and held until its dump.
        d_eff   = (cnt_eff == '0) ? clamp_dec(dec_log2) : d_q;
        n_m1    = MAX_DEC_LOG2'((32'd1 << d_eff) - 32'd1);
        last    = vld_pipe[1] && (cnt_eff == n_m1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            clr_pipe  <= '0;
            x1        <= '0;
            lo_i1     <= '0;
            lo_q1     <= '0;
            cnt       <= '0;
            d_q       <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[0], in_valid};
            clr_pipe  <= {clr_pipe[0], blk_clr};
            if (in_valid) begin
                x1    <= {~adc_in[DATA_W-1], adc_in[DATA_W-2:0]};
                lo_i1 <= lo_i;
                lo_q1 <= lo_q;
            end
            if (vld_pipe[0] && (ovf_i || ovf_q))
                sat_flag <= 1'b1;
            out_valid <= last;
            if (vld_pipe[1] || clr_pipe[1])
                d_q <= d_eff;
            if (vld_pipe[1])
                cnt <= last ? '0 : cnt_eff + 1'b1;
            else if (clr_pipe[1])
                cnt <= '0;
        end
    end

    iq_mix_lane u_lane_i (
        .clk      (clk),
        .rst      (rst),
        .x        (x1),
        .lo       (lo_i1),
        .mul_vld  (vld_pipe[0]),
        .acc_vld  (vld_pipe[1]),
        .acc_clr  (clr_pipe[1]),
        .acc_last (last),
        .d        (d_eff),
        .out      (out_i),
        .ovf      (ovf_i)
    );

    iq_mix_lane u_lane_q (
        .clk      (clk),
        .rst      (rst),
        .x        (x1),
        .lo       (lo_q1),
        .mul_vld  (vld_pipe[0]),
        .acc_vld  (vld_pipe[1]),
        .acc_clr  (clr_pipe[1]),
        .acc_last (last),
        .d        (d_eff),
        .out      (out_q),
        .ovf      (ovf_q)
    );

endmodule

// File: tb/tb_iq_ddc_demod.sv
// Bench for iq_ddc_demod: directed scenarios plus random soak, checked against
// a block-average reference model with strobe timing.
module tb_iq_ddc_demod;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        blk_clr = 1'b0;
    logic [15:0] adc_in = 16'h8000;
    logic [15:0] lo_i = '0;
    logic [15:0] lo_q = '0;
    logic [3:0]  dec_log2 = '0;
    logic        out_valid, sat_flag;
    logic [15:0] out_i, out_q;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cur_dec = 0;
    int got_i[$], got_q[$], got_c[$];
    int exp_i[$], exp_q[$], exp_c[$];

    int     m_cnt = 0;
    int     m_d = 0;
    longint m_acc_i = 0;
    longint m_acc_q = 0;
    bit     m_sat = 1'b0;

    iq_ddc_demod dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .adc_in    (adc_in),
        .lo_i      (lo_i),
        .lo_q      (lo_q),
        .dec_log2  (dec_log2),
        .blk_clr   (blk_clr),
        .out_valid (out_valid),
        .out_i     (out_i),
        .out_q     (out_q),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            got_i.push_back(int'($signed(out_i)));
            got_q.push_back(int'($signed(out_q)));
            got_c.push_back(cyc);
        end
    end

    task automatic chk(string tag, longint got, longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    function automatic longint fdiv(longint a, longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0)))
            q = q - 1;
        return q;
    endfunction

    // Ideal mixer: x*lo scaled by 2^-15 (floor), clipped to 16-bit signed.
    function automatic int mix(int x, int lo, output bit s);
        longint q;
        q = fdiv(longint'(x) * longint'(lo), 32768);
        s = 1'b0;
        if (q > 32767) begin q = 32767; s = 1'b1; end
        if (q < -32768) begin q = -32768; s = 1'b1; end
        return int'(q);
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic step(bit v, int x, int li, int lq, bit clr);
        int pi, pq;
        bit si, sq;
        longint n;
        @(negedge clk);
        in_valid = v;
        adc_in   = 16'(x) ^ 16'h8000;
        lo_i     = 16'(li);
        lo_q     = 16'(lq);
        blk_clr  = clr;
        dec_log2 = 4'(cur_dec);
        if (clr) begin
            m_cnt = 0; m_acc_i = 0; m_acc_q = 0;
        end
        if (v) begin
            pi = mix(x, li, si);
            pq = mix(x, lq, sq);
            if (si || sq) m_sat = 1'b1;
            if (m_cnt == 0) m_d = (cur_dec > 8) ? 8 : cur_dec;
            m_acc_i += pi;
            m_acc_q += pq;
            m_cnt++;
            n = longint'(1) << m_d;
            if (m_cnt == n) begin
                exp_i.push_back(int'(fdiv(m_acc_i, n)));
                exp_q.push_back(int'(fdiv(m_acc_q, n)));
                exp_c.push_back(cyc + 3);
                m_cnt = 0; m_acc_i = 0; m_acc_q = 0;
            end
        end
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; blk_clr = 1'b0;
        m_cnt = 0; m_acc_i = 0; m_acc_q = 0; m_sat = 1'b0;
        @(negedge clk);
        chk({tag, "_rst_valid"}, out_valid, 0);
        chk({tag, "_rst_i"}, out_i, 0);
        chk({tag, "_rst_q"}, out_q, 0);
        chk({tag, "_rst_sat"}, sat_flag, 0);
        rst = 1'b0;
    endtask

    task automatic check_out(string tag);
        int n;
        n = (got_i.size() < exp_i.size()) ? got_i.size() : exp_i.size();
        chk({tag, "_strobes"}, got_i.size(), exp_i.size());
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_i%0d", tag, i), got_i[i], exp_i[i]);
            chk($sformatf("%s_q%0d", tag, i), got_q[i], exp_q[i]);
            chk($sformatf("%s_cyc%0d", tag, i), got_c[i], exp_c[i]);
        end
        chk({tag, "_sat"}, sat_flag, m_sat);
        got_i.delete(); got_q.delete(); got_c.delete();
        exp_i.delete(); exp_q.delete(); exp_c.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("init_valid", out_valid, 0);
        chk("init_i", out_i, 0);
        chk("init_q", out_q, 0);
        chk("init_sat", sat_flag, 0);
        rst = 1'b0;

        // DC mix
        cur_dec = 2;
        for (int k = 0; k < 4; k++) step(1'b1, 16384, 32767, 0, 1'b0);
        idle(5);
        if (got_i.size() > 0) chk("dc_const_i", got_i[0], 16383);
        check_out("dc");

        // saturation, then inputs back to zero; flag must stay set
        cur_dec = 0;
        for (int k = 0; k < 3; k++) step(1'b1, -32768, -32768, 0, 1'b0);
        for (int k = 0; k < 2; k++) step(1'b1, 0, 0, 0, 1'b0);
        idle(5);
        if (got_i.size() > 0) chk("sat_const_i", got_i[0], 32767);
        chk("sat_sticky", sat_flag, 1);
        check_out("sat");

        // negative product truncation
        cur_dec = 1;
        for (int k = 0; k < 2; k++) step(1'b1, -1, 0, 1, 1'b0);
        idle(5);
        if (got_q.size() > 0) chk("neg_const_q", got_q[0], -1);
        check_out("neg");

        // gapped valid with a ratio change mid-block
        cur_dec = 3;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) cur_dec = 1;
            idle(int'($urandom_range(0, 5)));
            step(1'b1, rnd16(), rnd16(), rnd16(), 1'b0);
        end
        idle(5);
        check_out("gap");

        // blk_clr mid-block
        cur_dec = 2;
        for (int k = 0; k < 3; k++) step(1'b1, 1000, 32767, 0, 1'b0);
        step(1'b1, -1000, 32767, 0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, -1000, 32767, 0, 1'b0);
        idle(5);
        if (got_i.size() > 0) chk("clr_const_i", got_i[0], -1000);
        check_out("clr");

        // reset mid-block
        cur_dec = 2;
        for (int k = 0; k < 2; k++) step(1'b1, rnd16(), rnd16(), rnd16(), 1'b0);
        do_reset("mid");
        for (int k = 0; k < 4; k++) step(1'b1, rnd16(), rnd16(), rnd16(), 1'b0);
        idle(5);
        check_out("mid");

        // random soak: each segment opens with blk_clr and a fresh ratio
        for (int seg = 0; seg < 5; seg++) begin
            idle(3);
            cur_dec = (seg == 4) ? 12 : int'($urandom_range(0, 6));
            step(1'b1, rnd16(), rnd16(), rnd16(), 1'b1);
            for (int k = 0; k < 300; k++)
                step(($urandom % 4) != 0, rnd16(), rnd16(), rnd16(), ($urandom % 50) == 0);
            idle(5);
            check_out($sformatf("soak%0d", seg));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
